// File: rtl/coin_conditioner.sv
// Coin-path front-end: synchronizes, debounces and validates the three coin sensors, one pulse per coin.
// Define COIN_CONDITIONER_STATS_EN to add saturating accepted_count / rejected_count outputs.
module coin_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_5,
    input  logic       raw_10,
    input  logic       raw_25,
    input  logic       enable,
    output logic       coin_5,
    output logic       coin_10,
    output logic       coin_25,
    output logic       reject,
    output logic       busy
`ifdef COIN_CONDITIONER_STATS_EN
    ,
    output logic [7:0] accepted_count,
    output logic [7:0] rejected_count
`endif
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned ST_W    = 3;
    localparam int unsigned COIN_W  = 3;
    localparam int unsigned PULSE_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_DEBOUNCE = 3'd1;
    localparam logic [ST_W-1:0] ST_EMIT     = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT_REL = 3'd3;
    localparam logic [ST_W-1:0] ST_LOCKOUT  = 3'd4;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [COIN_W-1:0]  sync1_q;
    logic [COIN_W-1:0]  s_q;
    logic [ST_W-1:0]    state_q, state_d;
    logic [COIN_W-1:0]  pattern_q, pattern_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PULSE_W-1:0] pulse_q, pulse_d;
    logic               busy_q, busy_d;

    // Two-flop synchronizer on the raw sensor levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            s_q     <= '0;
        end else begin
            sync1_q <= {raw_25, raw_10, raw_5};
            s_q     <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            cnt_q     <= '0;
            pulse_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
        end
    end

    // Pulse is registered on the DEBOUNCE->EMIT edge so it coincides with the EMIT cycle
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        pulse_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (s_q != '0) begin
                    pattern_d = s_q;
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (s_q != pattern_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_EMIT;
                    if (enable && $onehot(pattern_q)) begin
                        pulse_d = {1'b0, pattern_q};
                    end else begin
                        pulse_d = 4'b1000;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (s_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign coin_5  = pulse_q[0];
    assign coin_10 = pulse_q[1];
    assign coin_25 = pulse_q[2];
    assign reject  = pulse_q[3];
    assign busy    = busy_q;

`ifdef COIN_CONDITIONER_STATS_EN
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rej_q, rej_d;

    // Saturating counters advance on the same edge that raises the pulse
    always_comb begin
        acc_d = acc_q;
        rej_d = rej_q;
        if ((pulse_d[2:0] != '0) && (acc_q != '1)) begin
            acc_d = acc_q + CNT_W'(1);
        end
        if (pulse_d[3] && (rej_q != '1)) begin
            rej_d = rej_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            rej_q <= '0;
        end else begin
            acc_q <= acc_d;
            rej_q <= rej_d;
        end
    end

    assign accepted_count = acc_q;
    assign rejected_count = rej_q;
`endif

endmodule

// File: doc/coin_conditioner.md
# coin_conditioner

Upstream front-end for the vending controller's coin path. It synchronizes the three raw coin-sensor levels, debounces them, and checks that exactly one denomination is present. It then emits a single-cycle `coin_5` / `coin_10` / `coin_25` pulse, or a `reject` pulse, per physical coin. Its outputs drive the coin inputs of the vending controller and coin accumulator directly. Each inserted coin yields at most one pulse regardless of sensor bounce or dwell time.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronized samples required to qualify a coin; legal range 2..255.
- `LOCKOUT_CYCLES`, default 8: cycles inputs are ignored after a coin is released; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `raw_5`, `raw_10`, `raw_25`  in  1 each  asynchronous sensor levels, high while a coin of that value is in the slot.
- `enable`  in  1  high: accept coins; low: every qualified coin is rejected.
- `coin_5`, `coin_10`, `coin_25`  out  1 each  registered one-cycle accept pulses.
- `reject`  out  1  registered one-cycle pulse for a rejected coin.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Each raw input passes through a 2-flop synchronizer. The synchronized 3-bit vector is `s`.
- FSM states are IDLE, DEBOUNCE, EMIT, WAIT_RELEASE and LOCKOUT.
- IDLE
  - Stays while `s == 0`.
  - On `s != 0`: latch `pattern <= s`, set `cnt <= 1`, go to DEBOUNCE.
- DEBOUNCE
  - If `s != pattern`: go to IDLE. The glitch is discarded, no output is produced, and IDLE may re-enter on the next cycle.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: go to EMIT and sample `enable` on this edge.
  - Else: `cnt <= cnt+1`.
- EMIT (exactly one cycle), selecting one output from `pattern` and the sampled `enable`:
  - Exactly one bit set and `enable` high: assert the matching `coin_*`.
  - More than one bit set, or `enable` low: assert `reject`.
  - Then go to WAIT_RELEASE.
- WAIT_RELEASE
  - Stays while `s != 0`; a coin held in the slot produces no further pulses.
  - On `s == 0`: clear `cnt`, go to LOCKOUT.
- LOCKOUT
  - Inputs are ignored.
  - After `LOCKOUT_CYCLES` cycles, go to IDLE.
- Pulse exclusivity: at most one of `coin_5`, `coin_10`, `coin_25`, `reject` is high in any cycle.
- Counter: `cnt` is 8 bits and never wraps within legal parameter ranges.

## Timing
- Reset values (on `reset` low, immediately and asynchronously):
  - state IDLE; synchronizers, `pattern` and `cnt` = 0.
  - `coin_*`, `reject` and `busy` = 0.
- Reset asserted during EMIT truncates the pulse. No pulse is emitted after reset releases unless a fresh qualification completes.
- Latency: raw rise sampled at edge E0. `s` is valid after E1. IDLE samples at E2. EMIT is entered at edge E(`DEBOUNCE_CYCLES`+1), and the pulse is high for the following cycle only. Default: pulse in the cycle after E5.
- `busy` is registered from state. It rises the cycle after the IDLE→DEBOUNCE edge and falls the cycle after LOCKOUT→IDLE.
- Coin spacing: minimum from one pulse to the next accepted coin's pulse is 1 (EMIT) + 1 (WAIT_RELEASE exit) + `LOCKOUT_CYCLES` + `DEBOUNCE_CYCLES` + 2 sync cycles.
- `enable` changes at any time other than the DEBOUNCE→EMIT edge have no effect on the current coin.

## Configuration
- `COIN_CONDITIONER_STATS_EN`
  - Defined: adds output ports `accepted_count` [7:0] and `rejected_count` [7:0].
  - Each counter increments on the cycle its pulse is emitted and saturates at 255.
  - Both counters reset to 0 and are cleared only by `reset`.
  - Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Clean `raw_10` high for 20 cycles, `enable` = 1, defaults → exactly one `coin_10` pulse, 1 cycle wide, in the cycle after E5; `busy` drops 8+ cycles after `raw_10` falls.
- `raw_25` bounces 1-0-1-0 at 1-cycle intervals, then holds high 10 cycles → exactly one `coin_25` pulse, timed from the start of the stable hold.
- `raw_5` and `raw_10` both high for 10 cycles → one `reject` pulse, no `coin_*`; with `COIN_CONDITIONER_STATS_EN`, `rejected_count` = 1.
- `enable` = 0 and clean `raw_5` → `reject` only. Second `raw_5` arriving during LOCKOUT then held → ignored until LOCKOUT ends, after which `coin_5` pulses once (`enable` = 1).
- `reset` pulled low during the EMIT cycle of a `coin_10` → pulse drops immediately; all outputs 0; no pulse after release while `raw_10` stays low.
- Stats build: 256 clean `raw_5` coins → `accepted_count` saturates at 255.
